// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM encoding and helpers shared by the multicycle ALU
package alu_pkg;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_XOR  = 4'b1101;
  localparam logic [3:0] OP_MUL  = 4'b1110;
  localparam logic [3:0] OP_DIVU = 4'b1111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic logic is_iterative(input logic [3:0] op);
    return op == OP_MUL || op == OP_DIVU;
  endfunction
endpackage

// File: rtl/alu_mc_iter_muldiv.sv
// alu_iter_muldiv: shift-add multiplier and restoring divider, one step per cycle
module alu_iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res
);
  localparam int CW = $clog2(WIDTH);

  // acc: product accumulator (MUL) or partial remainder (DIVU)
  // sa:  multiplicand shifting left (MUL) or dividend/quotient shift register (DIVU)
  // sb:  multiplier shifting right (MUL) or constant divisor (DIVU)
  logic [WIDTH-1:0] acc, sa, sb, acc_n, sa_n, sb_n;
  logic [WIDTH:0]   sh, diff;
  logic [CW-1:0]    cnt;
  logic             run, div, fit;

  // one iteration step for whichever operation is in flight
  always_comb begin
    sh    = {acc, sa[WIDTH-1]};
    diff  = sh - {1'b0, sb};
    fit   = ~diff[WIDTH];
    acc_n = div ? (fit ? diff[WIDTH-1:0] : sh[WIDTH-1:0]) : acc + (sb[0] ? sa : '0);
    sa_n  = div ? {sa[WIDTH-2:0], fit} : sa << 1;
    sb_n  = div ? sb : sb >> 1;
  end

  assign done = run && cnt == '0;
  assign res  = div ? sa_n : acc_n;

  // load operands on start, then step until the counter runs out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      sa  <= '0;
      sb  <= '0;
      cnt <= '0;
      run <= 1'b0;
      div <= 1'b0;
    end else if (start) begin
      acc <= '0;
      sa  <= a;
      sb  <= b;
      cnt <= CW'(WIDTH - 1);
      run <= 1'b1;
      div <= op_div;
    end else if (run) begin
      acc <= acc_n;
      sa  <= sa_n;
      sb  <= sb_n;
      cnt <= cnt - CW'(1);
      run <= cnt != '0;
    end
  end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multicycle ALU with valid/ready handshake and registered result/flags
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal,
  output logic             busy
);
  state_t               state, state_n;
  logic [WIDTH-1:0]     sum, dif, sc_res, iter_res;
  logic [SHAMT_W-1:0]   shamt;
  logic                 sc_ovf, sc_ill, accept, iter_go, iter_done;

  assign shamt     = b[SHAMT_W-1:0];
  assign sum       = a + b;
  assign dif       = a - b;
  assign in_ready  = state == IDLE || (state == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  // division by zero is answered immediately instead of iterating
  assign iter_go   = is_iterative(op) && !(op == OP_DIVU && b == '0);
  assign out_valid = state == DONE;
  assign busy      = state == BUSY;

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && iter_go),
    .op_div(op == OP_DIVU),
    .a     (a),
    .b     (b),
    .done  (iter_done),
    .res   (iter_res)
  );

  // single-cycle datapath and flag generation
  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    sc_ill = 1'b0;
    case (op)
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_NOR:  sc_res = ~(a | b);
      OP_ADD:  begin
        sc_res = sum;
        sc_ovf = a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1];
      end
      OP_SUB:  begin
        sc_res = dif;
        sc_ovf = a[WIDTH-1] != b[WIDTH-1] && dif[WIDTH-1] != a[WIDTH-1];
      end
      OP_SLT:  sc_res = WIDTH'($signed(a) < $signed(b));
      OP_SLTU: sc_res = WIDTH'(a < b);
      OP_SLL:  sc_res = a << shamt;
      OP_SRL:  sc_res = a >> shamt;
      OP_SRA:  sc_res = $signed(a) >>> shamt;
      OP_DIVU: sc_res = '1;
      OP_MUL:  sc_res = '0;
      default: sc_ill = 1'b1;
    endcase
  end

  // next-state logic: accept from IDLE or DONE, release DONE on out_ready
  always_comb begin
    state_n = state;
    if (accept)
      state_n = iter_go ? BUSY : DONE;
    else if (state == DONE && out_ready)
      state_n = IDLE;
    else if (state == BUSY && iter_done)
      state_n = DONE;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // result and flag registers, loaded when a result becomes final
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else if (accept && !iter_go) begin
      result   <= sc_res;
      zero     <= sc_res == '0;
      overflow <= sc_ovf;
      illegal  <= sc_ill;
    end else if (state == BUSY && iter_done) begin
      result   <= iter_res;
      zero     <= iter_res == '0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vectors with a scoreboard and a decoupled output monitor
module tb_alu_mc;
  import alu_pkg::*;
  localparam int W = 32;

  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, zero, overflow, illegal, busy;
  logic [W-1:0] result;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .overflow(overflow), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string        name;
    logic [W-1:0] r;
    logic         v;
    logic         il;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic seen = 1'b0;
  int   seen_cyc = 0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) seen = 1'b0;
    else begin
      if (out_valid && !seen) begin
        seen = 1'b1;
        seen_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h expected no output", result);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_result"}, result, e.r);
          chk({e.name, "_zero"}, W'(zero), W'(e.r == '0));
          chk({e.name, "_overflow"}, W'(overflow), W'(e.v));
          chk({e.name, "_illegal"}, W'(illegal), W'(e.il));
          chk({e.name, "_latency"}, W'(seen_cyc - e.acc), W'(e.lat));
        end
        seen = 1'b0;
      end
    end
  end

  task automatic issue(input string name, input logic [3:0] o, input logic [W-1:0] x, y, r,
                       input logic v, il, input int lat);
    int n = 0;
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: in_ready got 0 expected 1", name);
    end else sb.push_back('{name, r, v, il, lat, cyc});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = OP_XOR;
    a = ~x;
    b = ~y;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: pending results got %0d expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bc = 0, ir = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, '0);
    chk("rst_zero", W'(zero), '0);
    chk("rst_overflow", W'(overflow), '0);
    chk("rst_illegal", W'(illegal), '0);
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_busy", W'(busy), '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue("add_ovf",  OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1, 0, 1);
    issue("sub_zero", OP_SUB,  32'd5,        32'd5,        32'h00000000, 0, 0, 1);
    issue("sub_ovf",  OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1, 0, 1);
    issue("slt",      OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0, 1);
    issue("sltu",     OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0, 0, 1);
    issue("and",      OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 0, 0, 1);
    issue("or",       OP_OR,   32'h12340000, 32'h00005678, 32'h12345678, 0, 0, 1);
    issue("xor",      OP_XOR,  32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 0, 0, 1);
    issue("nor",      OP_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 0, 0, 1);
    issue("sll",      OP_SLL,  32'h00000001, 32'h00000021, 32'h00000002, 0, 0, 1);
    issue("srl",      OP_SRL,  32'h80000000, 32'h00000004, 32'h08000000, 0, 0, 1);
    issue("sra",      OP_SRA,  32'h80000000, 32'h00000024, 32'hF8000000, 0, 0, 1);
    issue("ill_1010", 4'b1010, 32'd5,        32'd6,        32'h00000000, 0, 1, 1);
    issue("ill_1001", 4'b1001, 32'd5,        32'd6,        32'h00000000, 0, 1, 1);
    drain();
    issue("mul", OP_MUL, 32'd12345, 32'd6789, 32'd83810205, 0, 0, 33);
    for (int i = 0; i < 40 && !out_valid; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (busy && in_ready) ir++;
    end
    chk("mul_busy_cycles", W'(bc), W'(32));
    chk("mul_in_ready_while_busy", W'(ir), W'(0));
    @(posedge clk);
    #1;
    issue("mul_wrap",  OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 0, 33);
    issue("divu",      OP_DIVU, 32'd100,      32'd7,        32'd14,       0, 0, 33);
    issue("divu_big",  OP_DIVU, 32'hFFFFFFFF, 32'd10,       32'h19999999, 0, 0, 33);
    issue("divu_by0",  OP_DIVU, 32'd100,      32'd0,        32'hFFFFFFFF, 0, 0, 1);
    issue("divu_small",OP_DIVU, 32'd5,        32'd9,        32'h00000000, 0, 0, 33);
    drain();
    out_ready = 1'b0;
    issue("hold_add", OP_ADD, 32'd3, 32'd4, 32'd7, 0, 0, 1);
    in_valid = 1'b1;
    op = OP_SUB;
    a = 32'd10;
    b = 32'd4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_in_ready", W'(in_ready), '0);
      chk("hold_out_valid", W'(out_valid), W'(1));
      chk("hold_result", result, 32'd7);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue("b2b_sub", OP_SUB, 32'd10, 32'd4, 32'd6, 0, 0, 1);
    drain();
    issue("abort_mul", OP_MUL, 32'd7, 32'd9, 32'd63, 0, 0, 33);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("abort_result", result, '0);
    chk("abort_zero", W'(zero), '0);
    chk("abort_overflow", W'(overflow), '0);
    chk("abort_illegal", W'(illegal), '0);
    chk("abort_out_valid", W'(out_valid), '0);
    chk("abort_busy", W'(busy), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue("post_rst_add", OP_ADD, 32'd1, 32'd2, 32'd3,  0, 0, 1);
    issue("post_rst_mul", OP_MUL, 32'd3, 32'd5, 32'd15, 0, 0, 33);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multicycle ALU; next generation of the datapath ALU for the MIPS core.
- Single-cycle ops: bitwise logic, add/sub, set-less-than and shifts. Iterative ops: multiply and unsigned divide.
- Valid/ready handshake on input and output, so the control unit can stall on long ops.
- Registered result, zero and overflow flags; sits between the register-file read stage and writeback.

Parameters:
WIDTH, 32, operand/result width in bits (>=8)
SHAMT_W, $clog2(WIDTH), shift-amount bits taken from b[SHAMT_W-1:0]

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  block accepts request this cycle
op  in  4  operation select
a  in  WIDTH  first operand
b  in  WIDTH  second operand / shift amount / divisor
out_valid  out  1  result available
out_ready  in  1  consumer takes result this cycle
result  out  WIDTH  operation result
zero  out  1  result == 0
overflow  out  1  signed overflow (ADD/SUB only), else 0
illegal  out  1  op code unsupported
busy  out  1  iterative op in progress

Behaviour:
- Op codes: AND 0000, OR 0001, ADD 0010, SLL 0011, SRL 0100, SRA 0101, SUB 0110, SLT 0111, SLTU 1000, XOR 1101, NOR 1100, MUL 1110, DIVU 1111.
- Codes 1001, 1010, 1011 are illegal: result 0, zero 1, illegal 1, latency 1.
- AND/OR/XOR/NOR are bitwise, not logical.
- SLT is signed; SLTU is unsigned. Both produce zero-extended 1 or 0.
- Shifts use b[SHAMT_W-1:0]; upper bits of b are ignored. SRA replicates a[WIDTH-1].
- overflow for ADD: a and b have the same sign and the sign of result differs. For SUB: a and b have different signs and the sign of result differs from a.
- MUL: low WIDTH bits of the unsigned product; one shift-add step per cycle.
- DIVU: restoring division, one quotient bit per cycle; result is the quotient.
  - b==0: result all-ones, no iteration, latency 1.
- Reset (async, rst_n=0):
  - Outputs: result=0, zero=0, overflow=0, illegal=0, out_valid=0, busy=0.
  - FSM to IDLE; iteration counter 0.
  - Asserting reset mid-operation aborts the op; no result is produced.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch op, a and b.
    - Single-cycle op (or DIVU with b==0): go to DONE with result registered. Latency is 1 cycle from acceptance to out_valid.
    - MUL/DIVU: go to BUSY, counter=WIDTH-1, busy=1.
  - BUSY: in_ready=0. One iteration step per cycle.
    - When counter==0, finish the last step and go to DONE. Total latency WIDTH+1 cycles from acceptance to out_valid.
  - DONE: out_valid=1. result and flags are held stable until out_ready.
    - out_ready=1: go to IDLE. in_ready=1 in the same cycle as out_ready=1 (combinational from out_ready), allowing back-to-back issue. A request accepted that cycle is latched.
    - out_ready=0: stay in DONE; in_ready=0.
- zero and overflow are computed from the final result and registered alongside it.
- in_valid while in_ready=0 is ignored; the requester must hold the request.
- Operands a and b may change after acceptance without effect.

Decomposition:
- Package alu_pkg: op-code localparams (OP_AND … OP_DIVU), FSM state encoding (IDLE, BUSY, DONE), helper function is_iterative(op).
- Sub-module alu_iter_muldiv:
  - Holds the WIDTH-cycle MUL/DIVU datapath: accumulator, partial remainder, counter.
  - Interface: start, op_div, a, b, done, res.
  - The top level keeps the FSM, the single-cycle combinational datapath and the output registers.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow 1, zero 0, out_valid exactly 1 cycle after acceptance.
- SUB 5−5 -> result 0, zero 1. SLT a=0xFFFFFFFF, b=1 -> 1. SLTU with the same operands -> 0. AND 0xF0F0F0F0 & 0x0FF00FF0 -> 0x00F000F0.
- SRA a=0x80000000, b=0x00000024 (shamt 4) -> 0xF8000000. NOR 0,0 -> 0xFFFFFFFF. op 1010 -> illegal 1, result 0.
- MUL 12345 × 6789 -> 83810205 after 33 cycles; busy high 32 cycles; in_ready 0 throughout.
- DIVU 100 / 7 -> 14 after 33 cycles. DIVU 100 / 0 -> 0xFFFFFFFF after 1 cycle.
- Hold out_ready=0 for 5 cycles after ADD: result stable, no new accept. Then back-to-back issue, one op per cycle with out_ready=1. Then rst_n pulse mid-MUL -> all outputs 0, next op is accepted normally.
